// File: rtl/recirc_ctrl_pkg.sv
// Shared definitions for the recirculator controller: default sizes and
// the one-hot state encoding used on the state output.
package recirc_ctrl_pkg;

  localparam int LANES_DEF = 4;
  localparam int UMB_W_DEF = 3;

  typedef enum logic [4:0] {
    ST_RESET  = 5'b00001,
    ST_INIT   = 5'b00010,
    ST_IDLE   = 5'b00100,
    ST_ACTIVE = 5'b01000,
    ST_ERROR  = 5'b10000
  } state_t;

endpackage

// File: rtl/recirc_ctrl_rr_arbiter.sv
// Round-robin grant over the non-empty lanes; the pointer holds the lane
// where the next search begins and moves only when a grant is issued.
module rr_arbiter #(
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [LANES-1:0] req,
  input  logic             en,
  output logic [LANES-1:0] grant
);

  localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic             hit;
  int               idx;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    grant   = '0;
    hit     = 1'b0;
    ptr_nxt = ptr;
    idx     = 0;
    for (int i = 0; i < LANES; i++) begin
      idx = int'(ptr) + i;
      if (idx >= LANES) idx = idx - LANES;
      if (en && !hit && req[idx]) begin
        grant[idx] = 1'b1;
        hit        = 1'b1;
        ptr_nxt    = (idx == LANES - 1) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together on the edge regardless of statement order.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ptr <= '0;
    end else if (hit) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/recirc_ctrl.sv
// Recirculator control FSM: sequences init/idle/active/error, latches the
// FIFO thresholds and issues round-robin pops to the lane FIFOs.
module recirc_ctrl
  import recirc_ctrl_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int UMB_W = UMB_W_DEF
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             init,
  input  logic [UMB_W-1:0] umbral_alto_in,
  input  logic [UMB_W-1:0] umbral_bajo_in,
  input  logic [LANES-1:0] fifo_empty,
  input  logic [LANES-1:0] fifo_error,
  input  logic             pause,
  output logic [LANES-1:0] pop,
  output logic             selector_IDLE,
  output logic [4:0]       state,
  output logic             idle_out,
  output logic             active_out,
  output logic             error_out,
  output logic [UMB_W-1:0] umbral_alto_out,
  output logic [UMB_W-1:0] umbral_bajo_out,
  output logic [LANES-1:0] error_lane
);

  state_t st;
  state_t nxt;
  logic   any_err;
  logic   all_empty;
  logic   arb_en;

  assign any_err   = |fifo_error;
  assign all_empty = &fifo_empty;
  assign arb_en    = (st == ST_ACTIVE) && !pause;
  assign state     = st;

  rr_arbiter #(.LANES(LANES)) u_arb (
    .clk     (clk),
    .reset_L (reset_L),
    .req     (~fifo_empty),
    .en      (arb_en),
    .grant   (pop)
  );

  // Priority in every live state: error, then init, then empty-based moves.
  always_comb begin
    nxt = st;
    case (st)
      ST_RESET:  nxt = ST_INIT;
      ST_INIT: begin
        if (any_err)    nxt = ST_ERROR;
        else if (!init) nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (any_err)         nxt = ST_ERROR;
        else if (init)       nxt = ST_INIT;
        else if (!all_empty) nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (any_err)                      nxt = ST_ERROR;
        else if (init)                    nxt = ST_INIT;
        else if (all_empty && pop == '0)  nxt = ST_IDLE;
      end
      ST_ERROR:  nxt = ST_ERROR;
      default:   nxt = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      st              <= ST_RESET;
      umbral_alto_out <= '0;
      umbral_bajo_out <= '0;
      error_lane      <= '0;
      selector_IDLE   <= 1'b0;
      idle_out        <= 1'b0;
      active_out      <= 1'b0;
      error_out       <= 1'b0;
    end else begin
      st <= nxt;
      if (st == ST_INIT) begin
        umbral_alto_out <= umbral_alto_in;
        umbral_bajo_out <= umbral_bajo_in;
      end
      if (nxt == ST_ERROR && st != ST_ERROR) begin
        error_lane <= fifo_error;
      end
      // Decodes come from the next state so they line up with state.
      selector_IDLE <= (nxt == ST_IDLE);
      idle_out      <= (nxt == ST_IDLE);
      active_out    <= (nxt == ST_ACTIVE);
      error_out     <= (nxt == ST_ERROR);
    end
  end

endmodule
